// File: rtl/sam_reg_write.sv
// sam_reg_write: MPU-side write port of the SAM control register.
// A write of RnW=0 to FFC0-FFDF selects bit A[4:1] and loads it with A[0].
// E is asynchronous to clk, so it is synchronized and edge-detected. The
// write is armed on the E rise and committed on the E fall. Bits 11/12 form
// a requested MPU rate that is moved to R only on a rate_safe strobe.
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   A, RnW, E        MPU address bus, read/write (0 = write), E clock
//   rate_safe        single-cycle strobe marking a safe rate switch point
//   V, F, P, M, TY   register fields (bits 0-2, 3-9, 10, 13-14, 15)
//   R                applied MPU rate (follows bits 11-12 via rate_safe)
//   reg_we           one-cycle pulse per committed register write
//   rate_change      one-cycle pulse when R updates
//   r_busy           registered (requested rate != applied rate)
module sam_reg_write (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic        RnW,
  input  logic        E,
  input  logic        rate_safe,
  output logic [2:0]  V,
  output logic [6:0]  F,
  output logic        P,
  output logic [1:0]  R,
  output logic [1:0]  M,
  output logic        TY,
  output logic        reg_we,
  output logic        rate_change,
  output logic        r_busy
);

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  // Address decode: a write into the FFC0-FFDF window.
  function automatic logic sam_hit(input logic [15:0] addr, input logic rnw);
    return (rnw == 1'b0) && (addr[15:5] == 11'b11111111110);
  endfunction

  logic       e_s1, e_s2, e_s3;
  logic       rise_s, fall_s;
  state_t     state_r, next_state_s;
  logic       arm_s, commit_s;
  logic [3:0] idx_r;
  logic       val_r;
  logic [15:0] ctrl_r;      // bits 11/12 hold the requested rate r_req
  logic [1:0] r_req_s;
  logic [1:0] r_applied_r;
  logic       reg_we_r, rate_change_r, r_busy_r;

  assign rise_s  = e_s2 & ~e_s3;
  assign fall_s  = ~e_s2 & e_s3;
  assign r_req_s = ctrl_r[12:11];

  // E synchronizer plus history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_s1 <= 1'b0;
      e_s2 <= 1'b0;
      e_s3 <= 1'b0;
    end else begin
      e_s1 <= E;
      e_s2 <= e_s1;
      e_s3 <= e_s2;
    end
  end

  // Next-state logic; a rise while armed re-evaluates the new access.
  always_comb begin
    next_state_s = state_r;
    arm_s        = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s && sam_hit(A, RnW)) begin
          arm_s        = 1'b1;
          next_state_s = ARMED;
        end else begin
          next_state_s = IDLE;
        end
      end
      ARMED: begin
        if (rise_s) begin
          if (sam_hit(A, RnW)) begin
            arm_s        = 1'b1;
            next_state_s = ARMED;
          end else begin
            next_state_s = IDLE;
          end
        end else if (fall_s) begin
          commit_s     = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = ARMED;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register and capture of the armed bit index/value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
      val_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (arm_s) begin
        idx_r <= A[4:1];
        val_r <= A[0];
      end
    end
  end

  // Register bank write and commit pulse; both change on the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r   <= 16'h0000;
      reg_we_r <= 1'b0;
    end else begin
      reg_we_r <= commit_s;
      if (commit_s) begin
        ctrl_r[idx_r] <= val_r;
      end
    end
  end

  // Rate transfer uses the r_req value from before any same-edge commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_applied_r   <= 2'b00;
      rate_change_r <= 1'b0;
      r_busy_r      <= 1'b0;
    end else begin
      r_busy_r <= (r_req_s != r_applied_r);
      if (rate_safe && (r_req_s != r_applied_r)) begin
        r_applied_r   <= r_req_s;
        rate_change_r <= 1'b1;
      end else begin
        rate_change_r <= 1'b0;
      end
    end
  end

  assign V           = ctrl_r[2:0];
  assign F           = ctrl_r[9:3];
  assign P           = ctrl_r[10];
  assign M           = ctrl_r[14:13];
  assign TY          = ctrl_r[15];
  assign R           = r_applied_r;
  assign reg_we      = reg_we_r;
  assign rate_change = rate_change_r;
  assign r_busy      = r_busy_r;

endmodule
